// File: rtl/scanline_pkg.sv
// scanline_fx shared definitions
// mode codes and the per-component dimming table
package scanline_pkg;

  localparam int SL_MAXW = 32;

  localparam logic [1:0] SL_OFF = 2'd0;
  localparam logic [1:0] SL_25  = 2'd1;
  localparam logic [1:0] SL_50  = 2'd2;
  localparam logic [1:0] SL_75  = 2'd3;

  // truncating shift dimming; result never exceeds c
  function automatic logic [SL_MAXW-1:0] dim(
    input logic [SL_MAXW-1:0] c,
    input logic [1:0]         mode
  );
    logic [SL_MAXW-1:0] res;
    res = c;
    unique case (mode)
      SL_OFF: res = c;
      SL_25:  res = c - (c >> 2);
      SL_50:  res = c >> 1;
      SL_75:  res = c >> 2;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/scanline_if.sv
// scanline_fx video stream bundle
// master drives the doubled stream, slave is the effect stage
interface scanline_if #(
  parameter int DW = 8
);

  logic          ce_pix;
  logic [1:0]    scanlines;
  logic          hs_in;
  logic          vs_in;
  logic [DW-1:0] r_in;
  logic [DW-1:0] g_in;
  logic [DW-1:0] b_in;
  logic          hs_out;
  logic          vs_out;
  logic [DW-1:0] r_out;
  logic [DW-1:0] g_out;
  logic [DW-1:0] b_out;

  modport master (
    output ce_pix, scanlines,
    output hs_in, vs_in,
    output r_in, g_in, b_in,
    input  hs_out, vs_out,
    input  r_out, g_out, b_out
  );

  modport slave (
    input  ce_pix, scanlines,
    input  hs_in, vs_in,
    input  r_in, g_in, b_in,
    output hs_out, vs_out,
    output r_out, g_out, b_out
  );

endinterface

// File: rtl/scanline_fx.sv
// scanline effect after the line doubler
// dims odd lines, realigns vsync to line starts
module scanline_fx
  import scanline_pkg::*;
#(
  parameter int DW = 8
) (
  input logic       clk_sys,
  input logic       reset_n,
  scanline_if.slave bus
);

  logic          hs_d_q, hs_d_d;
  logic          vs_d_q, vs_d_d;
  logic          vs_line_q, vs_line_d;
  logic          line_odd_q, line_odd_d;
  logic [1:0]    mode_lat_q, mode_lat_d;
  logic          hs_out_q, hs_out_d;
  logic          vs_out_q, vs_out_d;
  logic [DW-1:0] r_q, r_d;
  logic [DW-1:0] g_q, g_d;
  logic [DW-1:0] b_q, b_d;
  logic          line_start;
  logic          vs_rise;

  // edge detect, parity, mode latch, dim and vsync delay
  always_comb begin
    hs_d_d     = hs_d_q;
    vs_d_d     = vs_d_q;
    vs_line_d  = vs_line_q;
    line_odd_d = line_odd_q;
    mode_lat_d = mode_lat_q;
    hs_out_d   = hs_out_q;
    vs_out_d   = vs_out_q;
    r_d        = r_q;
    g_d        = g_q;
    b_d        = b_q;
    line_start = hs_d_q & ~bus.hs_in;
    vs_rise    = ~vs_d_q & bus.vs_in;
    if (bus.ce_pix) begin
      hs_d_d   = bus.hs_in;
      vs_d_d   = bus.vs_in;
      hs_out_d = bus.hs_in;
      if (line_odd_q) begin
        r_d = DW'(dim(SL_MAXW'(bus.r_in), mode_lat_q));
        g_d = DW'(dim(SL_MAXW'(bus.g_in), mode_lat_q));
        b_d = DW'(dim(SL_MAXW'(bus.b_in), mode_lat_q));
      end else begin
        r_d = bus.r_in;
        g_d = bus.g_in;
        b_d = bus.b_in;
      end
      if (vs_rise) begin
        line_odd_d = 1'b0;
        mode_lat_d = bus.scanlines;
      end else if (line_start) begin
        line_odd_d = ~line_odd_q;
      end
      if (line_start) begin
        vs_out_d  = vs_line_q;
        vs_line_d = bus.vs_in;
      end
    end
  end

  // state registers
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      hs_d_q     <= 1'b0;
      vs_d_q     <= 1'b0;
      vs_line_q  <= 1'b0;
      line_odd_q <= 1'b0;
      mode_lat_q <= SL_OFF;
      hs_out_q   <= 1'b0;
      vs_out_q   <= 1'b0;
      r_q        <= '0;
      g_q        <= '0;
      b_q        <= '0;
    end else begin
      hs_d_q     <= hs_d_d;
      vs_d_q     <= vs_d_d;
      vs_line_q  <= vs_line_d;
      line_odd_q <= line_odd_d;
      mode_lat_q <= mode_lat_d;
      hs_out_q   <= hs_out_d;
      vs_out_q   <= vs_out_d;
      r_q        <= r_d;
      g_q        <= g_d;
      b_q        <= b_d;
    end
  end

  assign bus.hs_out = hs_out_q;
  assign bus.vs_out = vs_out_q;
  assign bus.r_out  = r_q;
  assign bus.g_out  = g_q;
  assign bus.b_out  = b_q;

endmodule
